// File: rtl/constants.sv
// Shared SoC constants: memory-map slots plus the timer register layout.
package constants;

    // Timer slot in the word-addressed memory map
    localparam logic [31:0] TIMER_START = 32'h0008_5000;
    localparam int          TIMER_SIZE  = 5;

    // Timer register word offsets
    localparam logic [2:0] TIMER_CTRL     = 3'd0;
    localparam logic [2:0] TIMER_PRESCALE = 3'd1;
    localparam logic [2:0] TIMER_COUNT    = 3'd2;
    localparam logic [2:0] TIMER_COMPARE  = 3'd3;
    localparam logic [2:0] TIMER_STATUS   = 3'd4;

    // CTRL bit positions
    localparam int CTRL_EN_BIT         = 0;
    localparam int CTRL_AUTORELOAD_BIT = 1;
    localparam int CTRL_IRQEN_BIT      = 2;
    localparam int CTRL_W              = 3;

    // Field order mirrors the bit positions above (en is bit 0)
    typedef struct packed {
        logic irqen;
        logic autoreload;
        logic en;
    } timer_ctrl_t;

    // Replace only the bytes selected by sel; unselected bytes keep old_v
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts enabled cycles and emits a one-cycle tick every PRESCALE+1 of them.
module timer_prescaler (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [31:0] prescale_i,
    input  logic        clr_i,
    output logic        tick_o
);

    logic [31:0] pcnt_q, pcnt_d;

    // Tick on terminal count; clear has priority so a reconfigure restarts the period
    always_comb begin
        tick_o = en_i && (pcnt_q == prescale_i);
        pcnt_d = pcnt_q;
        if (clr_i)       pcnt_d = '0;
        else if (tick_o) pcnt_d = '0;
        else if (en_i)   pcnt_d = pcnt_q + 32'd1;
    end

    // Prescale counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pcnt_q <= '0;
        else         pcnt_q <= pcnt_d;
    end

endmodule

// File: rtl/wb_timer_slave.sv
// Wishbone single-transfer responder for the timer: CTRL/PRESCALE/COUNT/COMPARE/STATUS.
module wb_timer_slave
    import constants::*;
#(
    parameter logic [31:0] BASE_ADDR = TIMER_START,
    parameter int          NUM_REGS  = TIMER_SIZE
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq_o
);

    timer_ctrl_t ctrl_q, ctrl_d;
    logic [31:0] prescale_q, prescale_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q, match_d;
    logic        irq_q, irq_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;

    logic [31:0] offset;
    logic [2:0]  reg_idx;
    logic        in_range;
    logic        req, wr, rd;
    logic [31:0] rdata;
    logic        pclr, tick, is_match;

    timer_prescaler u_prescaler (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (ctrl_q.en),
        .prescale_i (prescale_q),
        .clr_i      (pclr),
        .tick_o     (tick)
    );

    // Decode, register updates, tick handling and the read mux
    always_comb begin
        // Unsigned offset: addresses below BASE_ADDR wrap high and fall out of range
        offset   = wb_adr_i - BASE_ADDR;
        reg_idx  = offset[2:0];
        in_range = offset < 32'(NUM_REGS);

        // Holding stb re-requests only after ack has dropped: one transfer per two cycles
        req = wb_cyc_i & wb_stb_i & ~ack_q;
        wr  = req & wb_we_i & in_range;
        rd  = req & ~wb_we_i & in_range;

        pclr = wr && ((reg_idx == TIMER_CTRL) || (reg_idx == TIMER_PRESCALE));

        ctrl_d = ctrl_q;
        if (wr && (reg_idx == TIMER_CTRL) && wb_sel_i[0])
            ctrl_d = timer_ctrl_t'(wb_dat_i[CTRL_W-1:0]);

        prescale_d = prescale_q;
        if (wr && (reg_idx == TIMER_PRESCALE))
            prescale_d = byte_merge(prescale_q, wb_dat_i, wb_sel_i);

        compare_d = compare_q;
        if (wr && (reg_idx == TIMER_COMPARE))
            compare_d = byte_merge(compare_q, wb_dat_i, wb_sel_i);

        // Tick advances COUNT; a bus write to COUNT overrides the tick
        is_match = (count_q == compare_q);
        count_d  = count_q;
        if (tick)
            count_d = (is_match && ctrl_q.autoreload) ? 32'd0 : count_q + 32'd1;
        if (wr && (reg_idx == TIMER_COUNT))
            count_d = byte_merge(count_q, wb_dat_i, wb_sel_i);

        // W1C first, then set, so a coincident match keeps the flag
        match_d = match_q;
        if (wr && (reg_idx == TIMER_STATUS) && wb_sel_i[0] && wb_dat_i[0])
            match_d = 1'b0;
        if (tick && is_match)
            match_d = 1'b1;

        irq_d = match_q & ctrl_q.irqen;

        rdata = '0;
        case (reg_idx)
            TIMER_CTRL:     rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
            TIMER_PRESCALE: rdata = prescale_q;
            TIMER_COUNT:    rdata = count_q;
            TIMER_COMPARE:  rdata = compare_q;
            TIMER_STATUS:   rdata = {31'd0, match_q};
            default:        rdata = '0;
        endcase

        ack_d = req;
        dat_d = rd ? rdata : 32'd0;
    end

    // State and bus-response registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            match_q    <= 1'b0;
            irq_q      <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            irq_q      <= irq_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_timer_slave.sv
// Directed bench for wb_timer_slave: bus handshake, prescaler, match/irq, W1C, byte lanes, reset.
module tb_wb_timer_slave;
    import constants::*;

    localparam logic [31:0] BASE = 32'h0008_5000;

    logic        clk;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        irq_o;

    int n_cmp;
    int n_bad;

    wb_timer_slave #(.BASE_ADDR(BASE), .NUM_REGS(5)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_dat_i (wdat),
        .wb_sel_i (sel),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .irq_o    (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transfer: drive just after a rising edge, request lands on the next edge,
    // ack is sampled on falling edges and the strobe is dropped as soon as it is seen.
    task automatic xfer(input logic w, input logic [31:0] off, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rdat, output int lat);
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = BASE + off; wdat = d; sel = s;
        lat  = 0;
        rdat = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (wb_ack_o) begin
                lat  = i;
                rdat = wb_dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (lat == 0) chk("ack_timeout", 32'(lat), 32'd2);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s = 4'hF);
        logic [31:0] dummy;
        int          lat;
        xfer(1'b1, off, d, s, dummy, lat);
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] d);
        int lat;
        xfer(1'b0, off, 32'd0, 4'hF, d, lat);
    endtask

    logic [31:0] r;
    int          lat, nack;

    initial begin
        n_cmp = 0; n_bad = 0;
        cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0; sel = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset values of every register, ack latency and single-cycle pulse
        for (int i = 0; i < 5; i++) begin
            xfer(1'b0, 32'(i), 32'd0, 4'hF, r, lat);
            chk($sformatf("rst_rd%0d", i), r, 32'd0);
            chk($sformatf("rst_lat%0d", i), 32'(lat), 32'd2);
            @(negedge clk);
            chk($sformatf("ack_pulse%0d", i), 32'(wb_ack_o), 32'd0);
        end

        // COMPARE=3 with autoreload+irq. PRESCALE=1 ticks every other cycle so that
        // back-to-back reads (one per two cycles) observe every COUNT value.
        wr(3, 32'd3);
        wr(1, 32'd1);
        wr(0, 32'h7);
        rd(2, r); chk("cnt_0", r, 32'd0);
        rd(2, r); chk("cnt_1", r, 32'd1);
        rd(2, r); chk("cnt_2", r, 32'd2);
        rd(2, r); chk("cnt_3", r, 32'd3);
        chk("irq_lag", 32'(irq_o), 32'd0);   // MATCH set on this edge, irq one cycle behind
        rd(2, r); chk("cnt_reload", r, 32'd0);
        chk("irq_rise", 32'(irq_o), 32'd1);
        rd(4, r); chk("match_set", r, 32'd1);

        // PRESCALE=4: ticks 5,10,15,20 cycles after enable; read lands 21 cycles after
        wr(0, 32'h0);
        wr(2, 32'd0);
        wr(3, 32'hFFFF_FFFF);
        wr(1, 32'd4);
        wr(0, 32'h5);
        repeat (19) @(posedge clk);
        rd(2, r); chk("presc4_cnt", r, 32'd4);

        // W1C with no new match: MATCH clears, irq follows one cycle later
        chk("irq_before_w1c", 32'(irq_o), 32'd1);
        wr(4, 32'h1);
        chk("irq_hold_w1c", 32'(irq_o), 32'd1);
        @(negedge clk);
        chk("irq_fall", 32'(irq_o), 32'd0);
        rd(4, r); chk("match_clr", r, 32'd0);

        // W1C on the same edge as a match tick: COUNT 10 -> 11, then match at 11
        wr(0, 32'h0);
        wr(1, 32'd0);
        wr(2, 32'd10);
        wr(3, 32'd11);
        wr(0, 32'h1);
        wr(4, 32'h1);
        wr(0, 32'h0);
        rd(4, r); chk("set_wins", r, 32'd1);

        // Wrap 0xFFFF_FFFF -> 0 with no flag, PRESCALE=0 ticks every cycle
        wr(4, 32'h1);
        rd(4, r); chk("match_clr2", r, 32'd0);
        wr(3, 32'd5);
        wr(2, 32'hFFFF_FFFF);
        wr(0, 32'h1);
        rd(2, r); chk("wrap_cnt", r, 32'd0);
        rd(4, r); chk("wrap_nomatch", r, 32'd0);
        // Bus write on a tick edge wins; one more tick before the read -> 0x1235
        wr(2, 32'h0000_1234);
        rd(2, r); chk("cnt_bus_wins", r, 32'h0000_1235);
        wr(0, 32'h0);

        // Byte lanes: only byte 1 written
        wr(3, 32'd0);
        wr(3, 32'hAABB_CCDD, 4'b0010);
        rd(3, r); chk("byte_sel", r, 32'h0000_CC00);

        // Out of range: acked with zero data, writes do not alias onto CTRL
        xfer(1'b0, 32'd7, 32'd0, 4'hF, r, lat);
        chk("oor7_dat", r, 32'd0);
        chk("oor7_lat", 32'(lat), 32'd2);
        xfer(1'b0, 32'hFFFF_FFFF, 32'd0, 4'hF, r, lat);
        chk("below_base_dat", r, 32'd0);
        chk("below_base_lat", 32'(lat), 32'd2);
        wr(8, 32'h7);
        rd(0, r); chk("oor_wr_ignored", r, 32'd0);

        // Strobe held for 6 cycles: ack every other cycle, 3 in total
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'd2; sel = 4'hF;
        nack = 0;
        repeat (6) begin
            @(negedge clk);
            if (wb_ack_o) nack++;
        end
        cyc = 1'b0; stb = 1'b0;
        chk("held_stb_acks", 32'(nack), 32'd3);

        // Reset before the request edge: the write is lost
        wr(3, 32'd0);
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'd3; wdat = 32'h55; sel = 4'hF;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd(3, r); chk("rst_write_lost", r, 32'd0);

        // Reset while ack is high: ack drops without waiting for a clock edge
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'd0;
        @(posedge clk);
        #2;
        chk("ack_before_rst", 32'(wb_ack_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ack_async_drop", 32'(wb_ack_o), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case something stalls outside a bounded wait
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
